// File: rtl/regbus_rr_arbiter.sv
// Round-robin arbiter that multiplexes several register-bus requesters onto
// one shared target, with an optional BUSY timeout that aborts a stalled
// transfer by returning an error response to the granted requester.

package regbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_a48_d32_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_a48_d32_rsp_t;

endpackage

module regbus_rr_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned TimeoutCycles = 256,
  parameter type         req_t         = regbus_pkg::reg_a48_d32_req_t,
  parameter type         rsp_t         = regbus_pkg::reg_a48_d32_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  req_t                      req_i [NumReq],
  output rsp_t                      rsp_o [NumReq],
  output req_t                      req_o,
  input  rsp_t                      rsp_i,
  output logic                      busy_o,
  output logic [$clog2(NumReq)-1:0] gnt_idx_o,
  output logic                      timeout_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0] CntThr = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ABORT
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   sel_q, sel_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              found;
  logic [IdxW-1:0]   pick;
  logic [IdxW-1:0]   sel_inc;
  rsp_t              abort_rsp;

  // Rotating priority search: first valid requester at or after rr_ptr_q.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      logic [IdxW-1:0] cand;
      cand = IdxW'((32'(rr_ptr_q) + i) % NumReq);
      if (!found && req_i[cand].valid) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign sel_inc = IdxW'((32'(sel_q) + 1) % NumReq);

  // Error response returned to the granted requester when a transfer is aborted.
  always_comb begin
    abort_rsp       = '0;
    abort_rsp.ready = 1'b1;
    abort_rsp.error = 1'b1;
  end

  // State, grant, rotation pointer and timeout counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; a dropped valid is treated like a completion without
  // error, and completion takes precedence over the timeout threshold.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req_i[sel_q].valid || rsp_i.ready) begin
          rr_ptr_d = sel_inc;
          state_d  = IDLE;
        end else begin
          cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
          if ((TimeoutCycles > 0) && (cnt_q == CntThr)) begin
            state_d = ABORT;
          end
        end
      end
      ABORT: begin
        rr_ptr_d = sel_inc;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output steering: only the granted requester sees the target, all others see zero.
  always_comb begin
    req_o     = '0;
    timeout_o = 1'b0;
    busy_o    = (state_q != IDLE);
    for (int unsigned i = 0; i < NumReq; i++) begin
      rsp_o[i] = '0;
    end
    case (state_q)
      BUSY: begin
        req_o        = req_i[sel_q];
        rsp_o[sel_q] = rsp_i;
      end
      ABORT: begin
        rsp_o[sel_q] = abort_rsp;
        timeout_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt_idx_o = sel_q;

endmodule

// File: tb/tb_regbus_rr_arbiter.sv
// Directed bench for regbus_rr_arbiter with four requesters and a short timeout.

module tb_regbus_rr_arbiter;
  import regbus_pkg::*;

  logic              clk;
  logic              rst_n;
  reg_a48_d32_req_t  req_i [4];
  reg_a48_d32_rsp_t  rsp_o [4];
  reg_a48_d32_req_t  req_o;
  reg_a48_d32_rsp_t  rsp_i;
  logic              busy;
  logic [1:0]        gnt_idx;
  logic              timeout;

  int vectors;
  int miscompares;

  regbus_rr_arbiter #(
    .NumReq        (4),
    .TimeoutCycles (4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req_i),
    .rsp_o     (rsp_o),
    .req_o     (req_o),
    .rsp_i     (rsp_i),
    .busy_o    (busy),
    .gnt_idx_o (gnt_idx),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      req_i[i]       = '0;
      req_i[i].addr  = 48'h1000 + 48'(i);
      req_i[i].wdata = 32'hA000_0000 + 32'(i);
    end
    rsp_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic check_all_rsp_zero(input string tag);
    logic all_zero;
    all_zero = 1'b1;
    for (int i = 0; i < 4; i++) if (rsp_o[i] !== '0) all_zero = 1'b0;
    check(tag, 64'(all_zero), 64'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clear_inputs();
    req_i[2].valid = 1'b1;
    rsp_i.ready    = 1'b1;
    #3;
    // Reset state: outputs zero even with activity on inputs
    check("rst_req_o_zero", 64'(req_o === '0), 64'd1);
    check_all_rsp_zero("rst_rsp_zero");
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gnt", 64'(gnt_idx), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);

    // Single request, target ready on the third cycle
    do_reset();
    req_i[2].valid = 1'b1;
    check("s_idle_valid", 64'(req_o.valid), 64'd0);
    check_all_rsp_zero("s_idle_rsp_zero");
    tick();
    check("s_c1_gnt", 64'(gnt_idx), 64'd2);
    check("s_c1_valid", 64'(req_o.valid), 64'd1);
    check("s_c1_addr", 64'(req_o.addr), 64'h1002);
    check("s_c1_busy", 64'(busy), 64'd1);
    check("s_c1_rdy", 64'(rsp_o[2].ready), 64'd0);
    tick();
    check("s_c2_busy", 64'(busy), 64'd1);
    tick();
    rsp_i.ready = 1'b1;
    rsp_i.rdata = 32'hCAFE_F00D;
    #1;
    check("s_c3_rdy", 64'(rsp_o[2].ready), 64'd1);
    check("s_c3_rdata", 64'(rsp_o[2].rdata), 64'hCAFE_F00D);
    check("s_c3_other_rdy", 64'(rsp_o[0].ready), 64'd0);
    req_i[2].valid = 1'b0;
    tick();
    rsp_i = '0;
    #1;
    check("s_c4_busy", 64'(busy), 64'd0);

    // Fairness: all valid, target always ready
    do_reset();
    for (int i = 0; i < 4; i++) req_i[i].valid = 1'b1;
    rsp_i.ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("f_busy", 64'(busy), 64'd1);
      check("f_gnt", 64'(gnt_idx), 64'(k % 4));
      check("f_rdy_gnt", 64'(rsp_o[k % 4].ready), 64'd1);
      check("f_rdy_other", 64'(rsp_o[(k + 1) % 4].ready), 64'd0);
      tick();
      check("f_idle", 64'(busy), 64'd0);
    end

    // Timeout with target never ready
    do_reset();
    req_i[1].valid = 1'b1;
    rsp_i.rdata    = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t_busy", 64'(busy), 64'd1);
      check("t_no_timeout", 64'(timeout), 64'd0);
      check("t_valid", 64'(req_o.valid), 64'd1);
    end
    tick();
    check("t_abort_timeout", 64'(timeout), 64'd1);
    check("t_abort_busy", 64'(busy), 64'd1);
    check("t_abort_valid", 64'(req_o.valid), 64'd0);
    check("t_abort_rdy", 64'(rsp_o[1].ready), 64'd1);
    check("t_abort_err", 64'(rsp_o[1].error), 64'd1);
    check("t_abort_rdata", 64'(rsp_o[1].rdata), 64'd0);
    check("t_abort_other", 64'(rsp_o[2].ready), 64'd0);
    req_i[1].valid = 1'b0;
    tick();
    check("t_after_timeout", 64'(timeout), 64'd0);
    check("t_after_busy", 64'(busy), 64'd0);
    req_i[1].valid = 1'b1;
    req_i[2].valid = 1'b1;
    tick();
    check("t_ptr_adv_gnt", 64'(gnt_idx), 64'd2);

    // Completion exactly at the timeout threshold wins
    do_reset();
    req_i[0].valid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rsp_i.ready = 1'b1;
    #1;
    check("r_rdy", 64'(rsp_o[0].ready), 64'd1);
    check("r_err", 64'(rsp_o[0].error), 64'd0);
    check("r_timeout", 64'(timeout), 64'd0);
    req_i[0].valid = 1'b0;
    tick();
    rsp_i = '0;
    #1;
    check("r_after_timeout", 64'(timeout), 64'd0);
    check("r_after_busy", 64'(busy), 64'd0);

    // Reset mid-BUSY with requester 3 granted
    do_reset();
    req_i[3].valid = 1'b1;
    tick();
    check("m_gnt3", 64'(gnt_idx), 64'd3);
    rst_n       = 1'b0;
    rsp_i.ready = 1'b1;
    #1;
    check("m_busy", 64'(busy), 64'd0);
    check("m_gnt", 64'(gnt_idx), 64'd0);
    check("m_req_o_zero", 64'(req_o === '0), 64'd1);
    check("m_rdy3", 64'(rsp_o[3].ready), 64'd0);
    rsp_i.ready    = 1'b0;
    req_i[1].valid = 1'b1;
    #1;
    rst_n = 1'b1;
    tick();
    check("m_restart_gnt", 64'(gnt_idx), 64'd1);

    // Requester drops valid mid-BUSY
    do_reset();
    req_i[0].valid = 1'b1;
    req_i[1].valid = 1'b1;
    tick();
    check("d_gnt0", 64'(gnt_idx), 64'd0);
    req_i[0].valid = 1'b0;
    #1;
    check("d_rdy0", 64'(rsp_o[0].ready), 64'd0);
    tick();
    check("d_idle", 64'(busy), 64'd0);
    check("d_idle_rdy0", 64'(rsp_o[0].ready), 64'd0);
    check("d_timeout", 64'(timeout), 64'd0);
    req_i[0].valid = 1'b1;
    tick();
    check("d_next_gnt", 64'(gnt_idx), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regbus_rr_arbiter.md
REGBUS_RR_ARBITER -- requirements
Module: regbus_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 4, meaning the number of register-bus requesters, range 2..16.
REQ-002 The block SHALL have parameter TimeoutCycles, default 256, meaning the BUSY cycles before abort; 0 disables the timeout.
REQ-003 The block SHALL have parameters req_t and rsp_t, default reg_a48_d32_req_t and reg_a48_d32_rsp_t, meaning the register-bus request type (valid, addr, write, wdata, wstrb) and response type (ready, rdata, error).
REQ-004 The block SHALL have port clk_i  in  1  clock; the block uses one clock only.
REQ-005 The block SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_i  in  req_t[NumReq]  requester-side requests.
REQ-007 The block SHALL have port rsp_o  out  rsp_t[NumReq]  requester-side responses.
REQ-008 The block SHALL have port req_o  out  req_t  request to the shared target.
REQ-009 The block SHALL have port rsp_i  in  rsp_t  response from the shared target.
REQ-010 The block SHALL have port busy_o  out  1  high when in BUSY or ABORT.
REQ-011 The block SHALL have port gnt_idx_o  out  $clog2(NumReq)  index of the granted requester.
REQ-012 The block SHALL have port timeout_o  out  1  single-cycle pulse in the ABORT cycle.

Function
REQ-013 The FSM SHALL have three states, IDLE, BUSY and ABORT.
REQ-014 In IDLE with any req_i[i].valid, the block SHALL register as sel_q the first valid index at or after rr_ptr_q (modulo NumReq), reset cnt_q to 0, and enter BUSY next cycle; arbitration latency is 1 cycle.
REQ-015 In IDLE, req_o.valid SHALL be 0 and every rsp_o[i] SHALL be all-zero.
REQ-016 In BUSY, req_o SHALL equal req_i[sel_q] and rsp_o[sel_q] SHALL equal rsp_i; every other rsp_o SHALL be all-zero.
REQ-017 In BUSY, req_i[sel_q].valid && rsp_i.ready completes the transfer: rr_ptr_q <= (sel_q+1) mod NumReq and the next state is IDLE.
REQ-018 In BUSY, if req_i[sel_q].valid drops without rsp_i.ready (protocol violation), the block SHALL go to IDLE, advance rr_ptr_q the same way, and signal no error.
REQ-019 In BUSY without completion, cnt_q SHALL increment and saturate at TimeoutCycles.
REQ-020 When TimeoutCycles>0 and cnt_q==TimeoutCycles-1 without completion, the next state SHALL be ABORT.
REQ-021 In ABORT, which lasts exactly 1 cycle, req_o.valid SHALL be 0, rsp_o[sel_q] SHALL be ready=1, error=1, rdata=0, and timeout_o SHALL be 1.
REQ-022 On leaving ABORT, the next state SHALL be IDLE and rr_ptr_q SHALL advance past sel_q.
REQ-023 A completion (rsp_i.ready) in the same cycle as the timeout threshold SHALL win: normal completion, no ABORT.
REQ-024 Requesters not granted SHALL see ready=0; their requests are held pending and not lost.
REQ-025 Back-to-back throughput SHALL be at most one transfer per 2 cycles (IDLE + BUSY), and rotation SHALL guarantee each continuously-valid requester is served within NumReq transfers.
REQ-026 gnt_idx_o SHALL equal sel_q at all times.
REQ-027 busy_o SHALL be high when the state is not IDLE.

Reset
REQ-028 On rst_ni low, asynchronously, the state SHALL be IDLE and sel_q, rr_ptr_q and cnt_q SHALL be 0.
REQ-029 During reset, req_o SHALL be all-zero, every rsp_o SHALL be all-zero, busy_o=0, gnt_idx_o=0 and timeout_o=0.
REQ-030 A reset asserted mid-BUSY SHALL abandon the transfer with no response to the requester; after release, arbitration restarts from index 0.

Verification
REQ-031 Single request, target ready after 3 cycles: requester 2 valid at cycle 0 -> gnt_idx_o=2 and req_o.valid at cycle 1, rsp_o[2].ready at cycle 3, busy_o=0 at cycle 4.
REQ-032 Fairness: all 4 requesters held valid, target always ready -> grant order 0,1,2,3,0,..., one transfer every 2 cycles.
REQ-033 Timeout, TimeoutCycles=4, target never ready: BUSY lasts 4 cycles, then ABORT with rsp_o[sel].ready=1 and error=1, timeout_o pulses once, req_o.valid=0 in ABORT.
REQ-034 Threshold race: target ready exactly on cycle TimeoutCycles-1 -> normal response with error=0, no timeout_o.
REQ-035 Reset mid-BUSY with requester 3 granted -> outputs zero immediately; after release with requesters 1 and 3 valid, requester 1 is granted first.
REQ-036 Requester drops valid mid-BUSY -> return to IDLE, no ready to that requester, next requester granted on the next arbitration.
